// File: rtl/ysyx_22050535_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22050535_ifu
// Instruction fetch unit. Holds the program counter and issues one fetch at a
// time to instruction memory. It buffers the returned word and hands it to
// decode together with its PC. Execute can redirect the PC at any point.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   fetch request handshake, req_addr = current PC
//   resp_valid/resp_data  memory response (always accepted), resp_err = fault
//   inst_valid/inst_ready decode handshake; inst, inst_pc, inst_fault payload
//   redirect_valid/_pc    load a new PC (jump / taken branch)
//
// All outputs decode directly from registers. There is no combinational path
// from any input to any output.
// ---------------------------------------------------------------------------
module ysyx_22050535_ifu #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  resp_valid,
    input  logic [31:0]           resp_data,
    input  logic                  resp_err,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [31:0]           inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_fault,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(3'd4);

    // Every PC load goes through here so that the PC always stays word aligned.
    function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] a);
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [31:0]             r_inst;
    logic                    r_fault;
    logic                    r_drop;   // an issued request is stale; discard its response

    state_t                  w_state_nxt;
    logic [ADDR_WIDTH-1:0]   w_pc_nxt;
    logic [31:0]             w_inst_nxt;
    logic                    w_fault_nxt;
    logic                    w_drop_nxt;

    // Next-state and next-register computation for the fetch FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_fault_nxt = r_fault;
        w_drop_nxt  = r_drop;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    w_pc_nxt = align_pc(redirect_pc);
                end else begin
                    w_pc_nxt = r_pc;
                end
                // A request that fires together with a redirect fetches the
                // old PC, so its response must be thrown away.
                if (req_ready) begin
                    w_state_nxt = S_WAIT;
                    w_drop_nxt  = redirect_valid;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect_valid && resp_valid) begin
                    // The stale response arrives with the redirect. Nothing is
                    // left outstanding, so refetch right away.
                    w_pc_nxt    = align_pc(redirect_pc);
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = S_REQ;
                end else if (redirect_valid) begin
                    w_pc_nxt   = align_pc(redirect_pc);
                    w_drop_nxt = 1'b1;
                end else if (resp_valid && r_drop) begin
                    w_drop_nxt  = 1'b0;
                    w_state_nxt = S_REQ;
                end else if (resp_valid) begin
                    w_inst_nxt  = resp_data;
                    w_fault_nxt = resp_err;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_HOLD: begin
                // A redirect has priority over +4 even when decode takes the
                // instruction in the same cycle.
                if (redirect_valid) begin
                    w_pc_nxt    = align_pc(redirect_pc);
                    w_state_nxt = S_REQ;
                end else if (inst_ready) begin
                    w_pc_nxt    = align_pc(r_pc + PC_STEP);
                    w_state_nxt = S_REQ;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, asynchronously reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= align_pc(RESET_PC);
            r_inst  <= 32'h0000_0000;
            r_fault <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_inst  <= w_inst_nxt;
            r_fault <= w_fault_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    assign req_valid  = (r_state == S_REQ);
    assign inst_valid = (r_state == S_HOLD);
    assign req_addr   = r_pc;
    assign inst_pc    = r_pc;
    assign inst       = r_inst;
    assign inst_fault = r_fault;

endmodule

// File: doc/ysyx_22050535_ifu.md
# ysyx_22050535_ifu

Instruction fetch unit for the ysyx_22050535 core. Holds the program counter, issues one-at-a-time fetch requests to instruction memory over a valid/ready handshake, and buffers each returned 32-bit instruction. It presents that instruction with its PC to the decode stage under a valid/ready handshake, and accepts PC redirects from execute for jumps and taken branches.

## Interface
- `RESET_PC`, default 32'h8000_0000: PC value after reset.
- `ADDR_WIDTH`, default 32: PC/address width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `req_valid` out 1: fetch request valid.
- `req_ready` in 1: memory accepts request.
- `req_addr` out ADDR_WIDTH: fetch address, equal to current PC.
- `resp_valid` in 1: memory response valid. Always accepted; there is no resp_ready.
- `resp_data` in 32: fetched instruction.
- `resp_err` in 1: access fault on this response.
- `inst_valid` out 1: instruction available to decode.
- `inst_ready` in 1: decode accepts instruction.
- `inst` out 32: instruction word.
- `inst_pc` out ADDR_WIDTH: PC of `inst`.
- `inst_fault` out 1: `inst` came from a faulted access.
- `redirect_valid` in 1: load new PC.
- `redirect_pc` in ADDR_WIDTH: redirect target.

## Operation
- State register takes one of four values: IDLE, REQ, WAIT, HOLD.
- Registers: `pc`, `inst_q`, `fault_q`, `drop`.
- Decoded outputs:
  - `req_valid = (state==REQ)`.
  - `inst_valid = (state==HOLD)`.
  - `req_addr = pc`.
  - `inst_pc = pc`.
- Any PC load (reset, redirect, increment) forces bits [1:0] to 0.
- IDLE: unconditionally go to REQ on the next edge.
- REQ:
  - `req_valid && req_ready` goes to WAIT.
  - `redirect_valid` loads `pc <= redirect_pc`.
  - If redirect and request fire in the same cycle: go to WAIT with `drop <= 1`, because the issued request is stale.
  - If redirect without fire: stay in REQ with the new PC.
- WAIT:
  - `redirect_valid` loads `pc <= redirect_pc` and sets `drop <= 1`.
  - `resp_valid && drop`: discard the response, clear `drop`, go to REQ.
  - `resp_valid && !drop`: latch `inst_q <= resp_data`, `fault_q <= resp_err`, go to HOLD.
  - If `redirect_valid` and `resp_valid` occur in the same cycle: discard the response, go to REQ with `pc <= redirect_pc`, `drop` stays 0.
- HOLD:
  - `inst_valid && inst_ready` without redirect: `pc <= pc + 4` (wraps modulo 2^ADDR_WIDTH), go to REQ.
  - `redirect_valid`: `pc <= redirect_pc`, go to REQ, held instruction dropped.
  - If redirect and handshake coincide: the transfer counts (decode has consumed it), and the PC takes the redirect target, not +4. Squashing is decode/execute's responsibility.
- `resp_valid` outside WAIT is a protocol violation; the block ignores it.
- `inst`, `inst_fault`, `inst_pc` stay stable while `inst_valid` is high and `inst_ready` is low.

## Timing
- Reset (asynchronous, `rst_n` low):
  - state = IDLE, `pc = RESET_PC`, `drop = 0`, `inst_q = 0`, `fault_q = 0`.
  - Hence `req_valid = 0`, `inst_valid = 0`, `req_addr = RESET_PC`, `inst = 0`, `inst_fault = 0`.
- First edge after `rst_n` rises: REQ, so `req_valid` is high in cycle 1.
- Reset assertion mid-transaction returns immediately to IDLE. Outstanding memory responses are the memory's responsibility to flush.
- Minimum latency: request accepted in cycle N; response earliest in N+1; `inst_valid` in N+2.
- Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect takes effect on the next edge. The next `req_addr` shows the target, except when a stale response is pending; the target is then issued one cycle after that response returns.
- No combinational path from any input to any output.

## Test plan
- Reset release with `req_ready=1`, memory returning 32'h0000_0413 one cycle after accept, `inst_ready=1`:
  - `req_addr` sequence is 8000_0000, 8000_0004, 8000_0008.
  - Each `inst_valid` pulse carries the matching `inst_pc`.
  - Each step takes 3 cycles.
- Backpressure: hold `inst_ready=0` for 5 cycles in HOLD:
  - `inst`/`inst_pc` stay stable, `req_valid` stays 0, `pc` does not advance.
  - After `inst_ready` rises, the next `req_addr` is PC+4.
- Redirect to 8000_0100 while in WAIT:
  - The next response is discarded with no `inst_valid`.
  - The following `req_addr` is 8000_0100.
- Redirect to 8000_0203 coincident with request fire:
  - The response is dropped.
  - The next `req_addr` is 8000_0200 (low bits cleared).
- `resp_err=1` with `resp_data`=DEADBEEF: `inst_valid` shows `inst_fault=1`, `inst`=DEADBEEF.
- Assert `rst_n` low in HOLD: `inst_valid` drops immediately and `pc` reads 8000_0000. Repeat with `pc`=FFFF_FFFC accepted: `pc` wraps to 0000_0000.
